// File: rtl/dec_key_pkg.sv
// Shared types for the decimal keypad entry controller: FSM states, BCD digit type, no-key code.
// Optional multi-key rejection is enabled in the controller by defining MULTI_KEY_ERR_EN.
package dec_key_pkg;

    localparam int unsigned NUM_KEYS = 10;
    localparam int unsigned BCD_W    = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        PRESENT  = 2'd3
    } state_e;

    typedef logic [BCD_W-1:0] bcd_t;

    // Encoder output when no key line is asserted; never a valid decimal digit.
    localparam bcd_t NO_KEY = 4'hF;

endpackage

// File: rtl/dec_prio_enc.sv
// Combinational 10-to-BCD priority encoder; the highest-index asserted key wins.
module dec_prio_enc
    import dec_key_pkg::*;
(
    input  logic [NUM_KEYS-1:0] key_i,
    output bcd_t                code_c_o,
    output logic                any_key_c_o,
    output logic                multi_key_c_o
);

    // Ascending scan so the last (highest) asserted key overrides lower ones.
    always_comb begin
        code_c_o = NO_KEY;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (key_i[i]) begin
                code_c_o = bcd_t'(i);
            end
        end
    end

    assign any_key_c_o   = |key_i;
    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign multi_key_c_o = |(key_i & (key_i - NUM_KEYS'(1)));

endmodule

// File: rtl/dec_key_entry_ctrl.sv
// Keypad entry controller: debounces key presses, shifts BCD digits in, presents them via valid/ready.
// Define MULTI_KEY_ERR_EN to reject multi-key samples with a key_err pulse instead of priority-resolving.
module dec_key_entry_ctrl
    import dec_key_pkg::*;
#(
    parameter int unsigned DIGITS          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_KEYS-1:0]          key_in,
    input  logic                         enter,
    input  logic                         clear,
    output logic [4*DIGITS-1:0]          digits_out,
    output logic [$clog2(DIGITS+1)-1:0]  digit_count,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         ovf,
    output logic                         key_err,
    output logic                         busy
);

    localparam int unsigned DW    = 4 * DIGITS;
    localparam int unsigned CW    = $clog2(DIGITS + 1);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    bcd_t code_c;
    logic any_key_c;
    logic multi_key_c;

    state_e           state_q,  state_d;
    bcd_t             cand_q,   cand_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [DW-1:0]    digits_q, digits_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             valid_q,  valid_d;
    logic             ovf_q,    ovf_d;
    logic             kerr_q,   kerr_d;
    logic             busy_q,   busy_d;

    dec_prio_enc u_enc (
        .key_i         (key_in),
        .code_c_o      (code_c),
        .any_key_c_o   (any_key_c),
        .multi_key_c_o (multi_key_c)
    );

`ifndef MULTI_KEY_ERR_EN
    // Priority encoding already resolves multi-key samples; the flag has no consumer here.
    logic multi_key_unused;
    assign multi_key_unused = multi_key_c;
`endif

    // Next-state and datapath update; clear overrides every transition.
    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        digits_d = digits_q;
        count_d  = count_q;
        valid_d  = valid_q;
        ovf_d    = 1'b0;
        kerr_d   = 1'b0;

        if (clear) begin
            state_d  = IDLE;
            cnt_d    = '0;
            digits_d = '0;
            count_d  = '0;
            valid_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enter && (count_q != '0)) begin
                        state_d = PRESENT;
                        valid_d = 1'b1;
`ifdef MULTI_KEY_ERR_EN
                    end else if (multi_key_c) begin
                        kerr_d  = 1'b1;
                        state_d = HELD;
`endif
                    end else if (any_key_c) begin
                        cand_d  = code_c;
                        cnt_d   = CNT_W'(1);
                        state_d = DEBOUNCE;
                    end
                end

                DEBOUNCE: begin
`ifdef MULTI_KEY_ERR_EN
                    if (multi_key_c) begin
                        kerr_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = HELD;
                    end else
`endif
                    if (any_key_c && (code_c == cand_q)) begin
                        if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                            // Final matching sample: commit on this edge.
                            cnt_d   = '0;
                            state_d = HELD;
                            if (count_q < CW'(DIGITS)) begin
                                digits_d = DW'({digits_q, cand_q});
                                count_d  = count_q + CW'(1);
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end

                HELD: begin
                    if (!any_key_c) begin
                        state_d = IDLE;
                    end
                end

                PRESENT: begin
                    if (out_ready) begin
                        digits_d = '0;
                        count_d  = '0;
                        valid_d  = 1'b0;
                        state_d  = IDLE;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cand_q   <= '0;
            cnt_q    <= '0;
            digits_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            kerr_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            kerr_q   <= kerr_d;
            busy_q   <= busy_d;
        end
    end

    assign digits_out  = digits_q;
    assign digit_count = count_q;
    assign out_valid   = valid_q;
    assign ovf         = ovf_q;
    assign key_err     = kerr_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_dec_key_entry_ctrl.sv
// Directed self-checking bench for dec_key_entry_ctrl (DIGITS=4, DEBOUNCE_CYCLES=4).
module tb_dec_key_entry_ctrl;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned DEB    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  key_in;
    logic        enter;
    logic        clear;
    logic [15:0] digits_out;
    logic [2:0]  digit_count;
    logic        out_valid;
    logic        out_ready;
    logic        ovf;
    logic        key_err;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    int ovf_seen = 0;
    int kerr_seen = 0;

    dec_key_entry_ctrl #(.DIGITS(DIGITS), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_in      (key_in),
        .enter       (enter),
        .clear       (clear),
        .digits_out  (digits_out),
        .digit_count (digit_count),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ovf         (ovf),
        .key_err     (key_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (ovf)     ovf_seen  <= ovf_seen + 1;
        if (key_err) kerr_seen <= kerr_seen + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int k);
        key_in = 10'(1) << k;
        cyc(DEB);
        key_in = '0;
        cyc(1);
    endtask

    initial begin
        rst = 1'b1; key_in = '0; enter = 1'b0; clear = 1'b0; out_ready = 1'b0;
        #3;
        chk("rst_digits", 32'(digits_out), 32'h0);
        chk("rst_count",  32'(digit_count), 32'h0);
        chk("rst_valid",  32'(out_valid), 32'h0);
        chk("rst_busy",   32'(busy), 32'h0);
        chk("rst_ovf",    32'(ovf), 32'h0);
        chk("rst_kerr",   32'(key_err), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1);

        // Key 3 held 6 cycles: commit after the 4th sample only.
        key_in = 10'h008;
        cyc(1);
        chk("k3_busy_deb", 32'(busy), 32'h1);
        cyc(2);
        chk("k3_count_pre", 32'(digit_count), 32'h0);
        cyc(1);
        chk("k3_count", 32'(digit_count), 32'h1);
        chk("k3_digits", 32'(digits_out), 32'h0003);
        cyc(2);
        chk("k3_single_commit", 32'(digit_count), 32'h1);
        chk("k3_busy_held", 32'(busy), 32'h1);
        key_in = '0;
        cyc(1);
        chk("k3_busy_release", 32'(busy), 32'h0);

        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        chk("clr_count", 32'(digit_count), 32'h0);
        chk("clr_digits", 32'(digits_out), 32'h0);

        // Bouncing key 5 never reaches 4 consecutive samples.
        key_in = 10'h020; cyc(2);
        key_in = '0;      cyc(1);
        key_in = 10'h020; cyc(2);
        key_in = '0;      cyc(1);
        chk("bounce_count", 32'(digit_count), 32'h0);
        chk("bounce_busy", 32'(busy), 32'h0);

        // Fill register with 1..4, then a 5th press overflows.
        press(1); press(2); press(3); press(4);
        chk("fill_digits", 32'(digits_out), 32'h1234);
        chk("fill_count", 32'(digit_count), 32'h4);
        chk("fill_no_ovf", 32'(ovf_seen), 32'h0);
        press(5);
        chk("ovf_digits", 32'(digits_out), 32'h1234);
        chk("ovf_count", 32'(digit_count), 32'h4);
        chk("ovf_once", 32'(ovf_seen), 32'h1);

        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        chk("clr_full_no_ovf", 32'(ovf_seen), 32'h1);

        // Keys 2 and 7 together.
        key_in = 10'h084;
        cyc(DEB);
`ifdef MULTI_KEY_ERR_EN
        chk("multi_count", 32'(digit_count), 32'h0);
        chk("multi_kerr", 32'(kerr_seen), 32'h1);
        chk("multi_held", 32'(busy), 32'h1);
`else
        chk("multi_count", 32'(digit_count), 32'h1);
        chk("multi_digits", 32'(digits_out), 32'h0007);
        chk("multi_no_kerr", 32'(kerr_seen), 32'h0);
`endif
        key_in = '0;
        cyc(1);
        chk("multi_release", 32'(busy), 32'h0);

        clear = 1'b1;
        cyc(1);
        clear = 1'b0;

        // Enter with empty register is ignored.
        enter = 1'b1;
        cyc(1);
        enter = 1'b0;
        chk("enter_empty_valid", 32'(out_valid), 32'h0);
        chk("enter_empty_busy", 32'(busy), 32'h0);

        // Present 42 with downstream stalling 3 cycles.
        press(4); press(2);
        chk("pres_digits_pre", 32'(digits_out), 32'h0042);
        enter = 1'b1;
        cyc(1);
        enter = 1'b0;
        chk("pres_valid_0", 32'(out_valid), 32'h1);
        chk("pres_busy", 32'(busy), 32'h1);
        for (int i = 1; i <= 3; i++) begin
            cyc(1);
            chk("pres_valid_stall", 32'(out_valid), 32'h1);
            chk("pres_digits_stable", 32'(digits_out), 32'h0042);
        end
        out_ready = 1'b1;
        cyc(1);
        chk("pres_valid_done", 32'(out_valid), 32'h0);
        chk("pres_digits_done", 32'(digits_out), 32'h0);
        chk("pres_count_done", 32'(digit_count), 32'h0);
        chk("pres_busy_done", 32'(busy), 32'h0);

        // Zero-wait acceptance: ready already high.
        press(9);
        enter = 1'b1;
        cyc(1);
        enter = 1'b0;
        chk("zw_valid", 32'(out_valid), 32'h1);
        chk("zw_digits", 32'(digits_out), 32'h0009);
        cyc(1);
        chk("zw_valid_drop", 32'(out_valid), 32'h0);
        chk("zw_count", 32'(digit_count), 32'h0);
        out_ready = 1'b0;

        // Async reset in the middle of a debounce.
        press(8);
        key_in = 10'h040;
        cyc(2);
        chk("rst_mid_busy_pre", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        chk("rst_mid_digits", 32'(digits_out), 32'h0);
        chk("rst_mid_count", 32'(digit_count), 32'h0);
        chk("rst_mid_busy", 32'(busy), 32'h0);
        key_in = '0;
        @(negedge clk);
        rst = 1'b0;
        cyc(1);

        // Enter beats a simultaneous key; clear aborts PRESENT.
        press(3);
        enter = 1'b1;
        key_in = 10'h020;
        cyc(1);
        enter = 1'b0;
        chk("beat_valid", 32'(out_valid), 32'h1);
        chk("beat_digits", 32'(digits_out), 32'h0003);
        cyc(1);
        chk("present_ignores_key", 32'(digit_count), 32'h1);
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        key_in = '0;
        chk("clr_pres_valid", 32'(out_valid), 32'h0);
        chk("clr_pres_digits", 32'(digits_out), 32'h0);
        chk("clr_pres_count", 32'(digit_count), 32'h0);
        chk("clr_pres_busy", 32'(busy), 32'h0);
        cyc(1);
        chk("final_busy", 32'(busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
